// File: rtl/opc6_bus8_bridge.sv
// opc6_bus8_bridge: splits opc6 16-bit bus cycles into byte cycles on an 8-bit SRAM/IO bus, stalling via cpu_clken.
// Optional OPC6_BUS8_READY_EN adds a mem_ready input that extends byte phases.
module opc6_bus8_bridge #(
  parameter int WAIT = 1,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_vpa,
  input  logic              cpu_vda,
  input  logic              cpu_vio,
  input  logic              cpu_rnw,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_dout,
  output logic [15:0]       cpu_din,
  output logic              cpu_clken,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
`ifdef OPC6_BUS8_READY_EN
  input  logic              mem_ready,
`endif
  output logic              mem_ce_b,
  output logic              mem_oe_b,
  output logic              mem_we_b,
  output logic              io_sel_b
);
  typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_t;
  state_t state, state_n;
  logic [15:0] addr_r, dout_r, addr_l, dout_l;
  logic rnw_r, vio_r, rnw_l, vio_l;
  logic [3:0] cnt;
  logic access, rdy, last, phase_n, hi_n;
  assign access = cpu_vpa | cpu_vda | cpu_vio;
`ifdef OPC6_BUS8_READY_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  assign last = (cnt >= 4'(WAIT)) && rdy;
  // in IDLE the outgoing strobes are computed from the live CPU request, afterwards from the latched copy
  assign addr_l = (state == IDLE) ? cpu_addr : addr_r;
  assign dout_l = (state == IDLE) ? cpu_dout : dout_r;
  assign rnw_l  = (state == IDLE) ? cpu_rnw  : rnw_r;
  assign vio_l  = (state == IDLE) ? cpu_vio  : vio_r;
  assign phase_n = (state_n == LO) || (state_n == HI);
  assign hi_n = state_n == HI;
  assign cpu_clken = reset || (state == IDLE && !access) || state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = access ? LO : IDLE;
      LO:      state_n = last ? (vio_r ? DONE : GAP) : LO;
      GAP:     state_n = HI;
      HI:      state_n = last ? DONE : HI;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cpu_din  <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
      mem_ce_b <= 1'b1;
      mem_oe_b <= 1'b1;
      mem_we_b <= 1'b1;
      io_sel_b <= 1'b1;
      addr_r   <= '0;
      dout_r   <= '0;
      rnw_r    <= 1'b1;
      vio_r    <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        addr_r <= cpu_addr;
        dout_r <= cpu_dout;
        rnw_r  <= cpu_rnw;
        vio_r  <= cpu_vio;
      end
      cnt <= (state_n != state) ? 4'd0 : (cnt == 4'hf ? cnt : cnt + 4'd1);
      mem_ce_b <= !(phase_n && !vio_l);
      io_sel_b <= !(phase_n && vio_l);
      mem_oe_b <= !(phase_n && rnw_l);
      mem_we_b <= !(phase_n && !rnw_l);
      if (phase_n) begin
        mem_addr <= vio_l ? ADDR_W'(addr_l) : ADDR_W'({addr_l, hi_n});
        if (!rnw_l) mem_dout <= hi_n ? dout_l[15:8] : dout_l[7:0];
      end
      if (state == LO && last && rnw_r) begin
        cpu_din[7:0] <= mem_din;
        if (vio_r) cpu_din[15:8] <= 8'h00;
      end
      if (state == HI && last && rnw_r) cpu_din[15:8] <= mem_din;
    end
  end
endmodule

// File: tb/tb_opc6_bus8_bridge.sv
// tb_opc6_bus8_bridge: scoreboard bench for opc6_bus8_bridge with a byte SRAM/IO model.
module tb_opc6_bus8_bridge;
  localparam int W = 1;
  typedef struct {
    string name;
    logic [15:0] din;
    int cyc;
  } item_t;
  logic clk = 0, reset = 1;
  logic cpu_vpa = 0, cpu_vda = 0, cpu_vio = 0, cpu_rnw = 1;
  logic [15:0] cpu_addr = 0, cpu_dout = 0, cpu_din;
  logic cpu_clken;
  logic [16:0] mem_addr;
  logic [7:0] mem_dout, mem_din, io_byte = 0;
  logic mem_ce_b, mem_oe_b, mem_we_b, io_sel_b;
`ifdef OPC6_BUS8_READY_EN
  logic mem_ready = 1;
`endif
  logic [7:0] mem [0:131071];
  item_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int we_low = 0, we_runs = 0, io_low = 0, ce_low = 0;

  opc6_bus8_bridge #(.WAIT(W), .ADDR_W(17)) dut (
    .clk(clk), .reset(reset), .cpu_vpa(cpu_vpa), .cpu_vda(cpu_vda), .cpu_vio(cpu_vio),
    .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_clken(cpu_clken), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
`ifdef OPC6_BUS8_READY_EN
    .mem_ready(mem_ready),
`endif
    .mem_ce_b(mem_ce_b), .mem_oe_b(mem_oe_b), .mem_we_b(mem_we_b), .io_sel_b(io_sel_b)
  );

  always #5 clk = ~clk;

  assign mem_din = !io_sel_b ? io_byte : ((!mem_ce_b && !mem_oe_b) ? mem[mem_addr] : 8'h00);
  always @(posedge clk) if (!mem_ce_b && !mem_we_b) mem[mem_addr] <= mem_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // strobe activity counters, sampled mid-cycle
  initial begin
    logic we_prev = 1;
    forever begin
      @(negedge clk);
      if (!mem_we_b) we_low++;
      if (!mem_we_b && we_prev) we_runs++;
      if (!io_sel_b) io_low++;
      if (!mem_ce_b) ce_low++;
      we_prev = mem_we_b;
    end
  end

  // monitor: every clken cycle outside reset completes the oldest pending CPU cycle
  initial begin
    int cyc = 0;
    item_t e;
    forever begin
      @(negedge clk);
      if (reset) cyc = 0;
      else begin
        cyc++;
        if (cpu_clken) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, "_din"}, 32'(cpu_din), 32'(e.din));
            chk({e.name, "_cycles"}, cyc, e.cyc);
          end
          cyc = 0;
        end
      end
    end
  end

  task automatic cpu_op(input string name, input logic pa, da, io, rw, input logic [15:0] a, d,
                        input logic [15:0] exp_din, input int exp_cyc);
    bit done = 0;
    sb.push_back('{name, exp_din, exp_cyc});
    cpu_vpa = pa; cpu_vda = da; cpu_vio = io; cpu_rnw = rw; cpu_addr = a; cpu_dout = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = cpu_clken;
    end
    chk({name, "_completed"}, 32'(done), 1);
    @(posedge clk);
    #1;
    cpu_vpa = 0; cpu_vda = 0; cpu_vio = 0; cpu_rnw = 1;
  endtask

  initial begin
    int s0, s1;
    bit hit;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h20] = 8'h34; mem[17'h21] = 8'h12;
    mem[17'h22] = 8'h78; mem[17'h23] = 8'h56;
    repeat (3) begin
      @(negedge clk);
      chk("reset_clken", 32'(cpu_clken), 1);
    end
    chk("reset_strobes", {28'd0, mem_ce_b, mem_oe_b, mem_we_b, io_sel_b}, 32'hf);
    chk("reset_din", 32'(cpu_din), 0);
    chk("reset_addr", 32'(mem_addr), 0);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;
    cpu_op("rd_mem", 1, 0, 0, 1, 16'h0010, 16'h0000, 16'h1234, 2*W+5);
    s0 = we_low; s1 = we_runs;
    cpu_op("wr_mem", 0, 1, 0, 0, 16'h0800, 16'hBEEF, 16'h1234, 2*W+5);
    chk("wr_we_cycles", we_low - s0, 2*(W+1));
    chk("wr_we_runs", we_runs - s1, 2);
    chk("wr_lo_byte", 32'(mem[17'h1000]), 32'hEF);
    chk("wr_hi_byte", 32'(mem[17'h1001]), 32'hBE);
    s0 = io_low; s1 = ce_low; io_byte = 8'hA5;
    cpu_op("rd_io", 0, 0, 1, 1, 16'h00FE, 16'h0000, 16'h00A5, W+3);
    chk("io_sel_cycles", io_low - s0, W+1);
    chk("io_ce_cycles", ce_low - s1, 0);
    chk("io_addr", 32'(mem_addr), 32'h000FE);
    cpu_op("rd_b2b", 1, 0, 0, 1, 16'h0011, 16'h0000, 16'h5678, 2*W+5);
    s0 = io_low; s1 = ce_low;
    cpu_op("idle", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h5678, 1);
    chk("idle_strobes", (io_low - s0) + (ce_low - s1), 0);
    cpu_op("wr_b2b", 0, 1, 0, 0, 16'h0012, 16'hCAFE, 16'h5678, 2*W+5);
    chk("b2b_lo_byte", 32'(mem[17'h24]), 32'hFE);
    chk("b2b_hi_byte", 32'(mem[17'h25]), 32'hCA);
`ifdef OPC6_BUS8_READY_EN
    fork
      begin
        for (int i = 0; i < 50 && mem_oe_b; i++) @(negedge clk);
        @(posedge clk); #1 mem_ready = 0;
        repeat (5) @(posedge clk);
        #1 mem_ready = 1;
      end
    join_none
    cpu_op("rd_ready", 1, 0, 0, 1, 16'h0010, 16'h0000, 16'h1234, 2*W+10);
`endif
    cpu_vda = 1; cpu_rnw = 0; cpu_addr = 16'h0100; cpu_dout = 16'h1111;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = !mem_we_b && mem_addr[0];
    end
    chk("abort_hi_reached", 32'(hit), 1);
    @(posedge clk); #1 reset = 1;
    cpu_vda = 0; cpu_rnw = 1;
    @(posedge clk); #1;
    chk("abort_strobes", {28'd0, mem_ce_b, mem_oe_b, mem_we_b, io_sel_b}, 32'hf);
    chk("abort_clken", 32'(cpu_clken), 1);
    chk("abort_din", 32'(cpu_din), 0);
    reset = 0; io_byte = 8'h3C;
    cpu_op("post_abort_io", 0, 0, 1, 1, 16'h0042, 16'h0000, 16'h003C, W+3);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
